gate_netlist_eval: RTL and testbench



---
 rtl/gate_netlist_eval.sv | 171 +++++++++++++++++
 tb/tb_gate_netlist_eval.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_netlist_eval.sv
// ---------------------------------------------------------------------------
// gate_netlist_eval
//
// Bit-sliced evaluator for gate-level netlists. A wire memory of DEPTH
// entries, each WIDTH lanes wide, is updated by a stream of two-input gate
// instructions. Every lane is evaluated with the same 4-bit truth table:
//   out[i] = gateChoice[{~a[i], ~b[i]}]
// (0=const0, 1=AND, 3=a, 5=b, 6=XOR, 7=OR, 8=NOR, 9=XNOR, 14=NAND, 15=const1).
//
// Pipeline:
//   accept cycle T : operands read (with bypass from the pending register),
//                    result registered into the pending register.
//   cycle T+1      : pending result written into the wire memory.
// Bypass from the pending register gives zero-stall dependent chains.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ldValid/ldAddr/ldData  host load of one wire (blocks instruction accept)
//   inValid/inReady    instruction handshake (inReady = !rst && !ldValid)
//   gateChoice, srcA, srcB, dst  instruction fields
//   rdAddr/rdData      registered, write-first read-back (1-cycle latency)
//   busy               pending register holds an unretired result
//
// Optional build macro GATE_EVAL_STATS_EN adds saturating 32-bit counters:
//   opCount      accepted instructions
//   hazardCount  accepted instructions that used the bypass on any operand
//
// Wire memory is not cleared by reset; software loads wires before use.
// Indices >= DEPTH are ignored on write and read back as 0.
// ---------------------------------------------------------------------------
module gate_netlist_eval #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ldValid,
  input  logic [AW-1:0]    ldAddr,
  input  logic [WIDTH-1:0] ldData,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       gateChoice,
  input  logic [AW-1:0]    srcA,
  input  logic [AW-1:0]    srcB,
  input  logic [AW-1:0]    dst,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData,
  output logic             busy
`ifdef GATE_EVAL_STATS_EN
  ,
  output logic [31:0]      opCount,
  output logic [31:0]      hazardCount
`endif
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             pend_valid_q, pend_valid_d;
  logic [AW-1:0]    pend_dst_q,   pend_dst_d;
  logic [WIDTH-1:0] pend_data_q,  pend_data_d;
  logic [WIDTH-1:0] rd_data_q,    rd_data_d;

  logic             accept;
  logic             byp_a, byp_b;
  logic             a_ok, b_ok, rd_ok, ld_ok, pend_ok;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic             retire_we, load_we;

  // Range checks are done one bit wider so they stay meaningful for
  // non-power-of-two DEPTH.
  always_comb begin
    a_ok    = {1'b0, srcA}       < DEPTH_W;
    b_ok    = {1'b0, srcB}       < DEPTH_W;
    rd_ok   = {1'b0, rdAddr}     < DEPTH_W;
    ld_ok   = {1'b0, ldAddr}     < DEPTH_W;
    pend_ok = {1'b0, pend_dst_q} < DEPTH_W;
  end

  always_comb begin
    inReady = !rst && !ldValid;
    accept  = inValid && inReady;

    byp_a = pend_valid_q && (srcA == pend_dst_q);
    byp_b = pend_valid_q && (srcB == pend_dst_q);

    op_a = '0;
    if (byp_a)     op_a = pend_data_q;
    else if (a_ok) op_a = mem_q[srcA];

    op_b = '0;
    if (byp_b)     op_b = pend_data_q;
    else if (b_ok) op_b = mem_q[srcB];

    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = gateChoice[{~op_a[i], ~op_b[i]}];
    end

    // A load to the same wire supersedes the retiring result.
    load_we   = ldValid && !rst && ld_ok;
    retire_we = pend_valid_q && !rst && pend_ok &&
                !(ldValid && (ldAddr == pend_dst_q));

    // Retire happens every non-reset cycle; only a new accept refills it.
    pend_valid_d = accept;
    pend_dst_d   = accept ? dst    : pend_dst_q;
    pend_data_d  = accept ? result : pend_data_q;

    // Write-first read-back: a same-cycle load or retire is visible.
    rd_data_d = '0;
    if (rd_ok) begin
      if (load_we && (ldAddr == rdAddr))
        rd_data_d = ldData;
      else if (retire_we && (pend_dst_q == rdAddr))
        rd_data_d = pend_data_q;
      else
        rd_data_d = mem_q[rdAddr];
    end
  end

  always_ff @(posedge clk) begin
    if (retire_we) mem_q[pend_dst_q] <= pend_data_q;
    if (load_we)   mem_q[ldAddr]     <= ldData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_dst_q   <= pend_dst_d;
      pend_data_q  <= pend_data_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rdData = rd_data_q;
  assign busy   = pend_valid_q;

`ifdef GATE_EVAL_STATS_EN
  logic [31:0] op_count_q,  op_count_d;
  logic [31:0] haz_count_q, haz_count_d;

  always_comb begin
    op_count_d  = op_count_q;
    haz_count_d = haz_count_q;
    if (accept && (op_count_q != '1))
      op_count_d = op_count_q + 32'd1;
    if (accept && (byp_a || byp_b) && (haz_count_q != '1))
      haz_count_d = haz_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q  <= '0;
      haz_count_q <= '0;
    end else begin
      op_count_q  <= op_count_d;
      haz_count_q <= haz_count_d;
    end
  end

  assign opCount     = op_count_q;
  assign hazardCount = haz_count_q;
`endif

endmodule

// File: tb/tb_gate_netlist_eval.sv
// Scoreboard bench for gate_netlist_eval. The reference model treats the
// wire memory as an architectural array: each accepted instruction becomes
// a deferred write that commits at the start of the next non-reset cycle
// and is dropped by reset.
module tb_gate_netlist_eval;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             ldValid;
  logic [AW-1:0]    ldAddr;
  logic [WIDTH-1:0] ldData;
  logic             inValid;
  logic             inReady;
  logic [3:0]       gateChoice;
  logic [AW-1:0]    srcA, srcB, dst;
  logic [AW-1:0]    rdAddr;
  logic [WIDTH-1:0] rdData;
  logic             busy;
`ifdef GATE_EVAL_STATS_EN
  logic [31:0]      opCount, hazardCount;
`endif

  gate_netlist_eval #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ldValid(ldValid), .ldAddr(ldAddr), .ldData(ldData),
    .inValid(inValid), .inReady(inReady), .gateChoice(gateChoice),
    .srcA(srcA), .srcB(srcB), .dst(dst),
    .rdAddr(rdAddr), .rdData(rdData), .busy(busy)
`ifdef GATE_EVAL_STATS_EN
    , .opCount(opCount), .hazardCount(hazardCount)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [7:0]  exp;
    bit          chk;
    bit          busy;
    logic [31:0] ops;
    logic [31:0] haz;
  } entry_t;

  entry_t sb[$];

  // Reference model state
  logic [7:0]  m [DEPTH];
  bit          known [DEPTH];
  bit          pv = 0;
  int          pd = 0;
  logic [7:0]  pdat;
  bit          pk;
  logic [31:0] ops = 0;
  logic [31:0] haz = 0;

  function automatic logic [7:0] gate_ref(input logic [3:0] ch, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx  = (a[i] ? 0 : 2) + (b[i] ? 0 : 1);
      r[i] = ch[idx];
    end
    return r;
  endfunction

  // Inputs are driven 1 time unit after a rising edge; they take effect on
  // the next rising edge.
  task automatic drive(input bit r, input bit l, input int la, input logic [7:0] ldd,
                       input bit v, input logic [3:0] c, input int a, input int b,
                       input int d, input int ra,
                       input bit cuse = 0, input logic [7:0] cexp = 8'h00);
    entry_t e;
    bit acc;
    rst = r; ldValid = l; ldAddr = AW'(la); ldData = ldd;
    inValid = v; gateChoice = c; srcA = AW'(a); srcB = AW'(b); dst = AW'(d);
    rdAddr = AW'(ra);
    #1;
    check("inReady", {31'd0, inReady}, {31'd0, (!r && !l)});
    acc = v && !r && !l;
    if (r) begin
      pv = 0; ops = 0; haz = 0;
      e.exp = 8'h00; e.chk = 1;
    end else begin
      bit had;
      int hd;
      had = pv; hd = pd;
      if (pv) begin m[pd] = pdat; known[pd] = pk; end
      pv = 0;
      if (l) begin m[la] = ldd; known[la] = 1; end
      e.exp = m[ra]; e.chk = known[ra];
      if (acc) begin
        if (had && (a == hd || b == hd)) haz++;
        ops++;
        pv = 1; pd = d;
        pdat = gate_ref(c, m[a], m[b]);
        pk = known[a] && known[b];
      end
    end
    if (cuse) begin e.exp = cexp; e.chk = 1; end
    e.busy = acc; e.ops = ops; e.haz = haz; e.cyc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int ra = 0);
    drive(0, 0, 0, 8'h00, 0, 4'd0, 0, 0, 0, ra);
  endtask
  task automatic load(input int a, input logic [7:0] d);
    drive(0, 1, a, d, 0, 4'd0, 0, 0, 0, a);
  endtask
  task automatic op(input logic [3:0] c, input int a, input int b, input int d, input int ra = 0);
    drive(0, 0, 0, 8'h00, 1, c, a, b, d, ra);
  endtask
  task automatic rd_const(input int ra, input logic [7:0] v);
    drive(0, 0, 0, 8'h00, 0, 4'd0, 0, 0, 0, ra, 1, v);
  endtask

  // Monitor: pops the entry of the previous cycle and compares outputs.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      entry_t e;
      e = sb.pop_front();
      if (e.chk) check("rdData", {24'd0, rdData}, {24'd0, e.exp});
      check("busy", {31'd0, busy}, {31'd0, e.busy});
`ifdef GATE_EVAL_STATS_EN
      check("opCount", opCount, e.ops);
      check("hazardCount", hazardCount, e.haz);
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp6 [6];
    logic [3:0] ch6  [6];
    exp6 = '{8'hC0, 8'h3C, 8'hFC, 8'h03, 8'hC3, 8'h3F};
    ch6  = '{4'd1, 4'd6, 4'd7, 4'd8, 4'd9, 4'd14};
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
    rst = 1; ldValid = 0; ldAddr = 0; ldData = 0; inValid = 0;
    gateChoice = 0; srcA = 0; srcB = 0; dst = 0; rdAddr = 0;
    @(posedge clk); #1;
    drive(1, 0, 0, 8'h00, 0, 4'd0, 0, 0, 0, 0);
    drive(1, 0, 0, 8'h00, 1, 4'd1, 0, 0, 0, 3);

    for (int i = 0; i < DEPTH; i++) load(i, 8'($urandom));

    // Basic truth tables
    load(0, 8'hF0);
    load(1, 8'hCC);
    for (int i = 0; i < 6; i++) op(ch6[i], 0, 1, 2 + i);
    idle();
    for (int i = 0; i < 6; i++) rd_const(2 + i, exp6[i]);

    // Dependent chain, zero stalls
    op(4'd6, 0, 1, 2);
    op(4'd1, 2, 0, 3);
    op(4'd12, 3, 3, 4);
    idle();
    rd_const(3, 8'h30);
    rd_const(4, 8'hCF);

    // Load colliding with pending destination
    op(4'd1, 0, 1, 10);
    drive(0, 1, 10, 8'h5A, 1, 4'd15, 0, 1, 11, 10, 1, 8'h5A);
    idle();
    rd_const(10, 8'h5A);

    // Constants
    op(4'd0, 0, 1, 5);
    op(4'd15, 0, 1, 6);
    idle();
    rd_const(5, 8'h00);
    rd_const(6, 8'hFF);

    // Reset discards a pending write
    load(9, 8'h77);
    op(4'd6, 0, 1, 9);
    drive(1, 0, 0, 8'h00, 0, 4'd0, 0, 0, 0, 9);
    idle(9);
    rd_const(9, 8'h77);

    // All 16 encodings on every lane combination
    for (int c = 0; c < 16; c++) op(4'(c), 0, 1, 20, 20);
    idle(20);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, l, v;
      r = ($urandom_range(199) == 0);
      l = !r && ($urandom_range(4) == 0);
      v = ($urandom_range(9) < 7);
      drive(r, l, $urandom_range(15), 8'($urandom), v, 4'($urandom),
            $urandom_range(15), $urandom_range(15), $urandom_range(15),
            ($urandom_range(3) == 0) ? $urandom_range(63) : $urandom_range(15));
    end
    idle();
    idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
